// File: rtl/br_resolve_pkg.sv
// ============================================================================
// Module   : br_resolve_pkg
// Brief    : Shared types and constants for the EX-stage branch resolver.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package br_resolve_pkg;

    localparam int c_pc_w = 32;
    localparam logic [c_pc_w-1:0] c_instr_step = 32'd4;

    typedef struct packed {
        logic              valid;
        logic [c_pc_w-1:0] pc;
        logic              taken;
        logic [c_pc_w-1:0] target;
        logic              is_branch;
    } upd_pkt_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } sq_state_t;

endpackage

`default_nettype wire

// File: rtl/br_resolve_if.sv
// ============================================================================
// Module   : br_resolve_if
// Brief    : EX-side inputs, flush/redirect and BTB update bundle of br_resolve.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface br_resolve_if
    import br_resolve_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic              stall;
    logic              ex_valid;
    logic              pred_taken;
    logic [c_pc_w-1:0] pred_pc;
    logic              is_branch;
    logic              actual_taken;
    logic [c_pc_w-1:0] br_target;

    logic              flush;
    logic [c_pc_w-1:0] redirect_pc;
    logic              upd_valid;
    logic [c_pc_w-1:0] upd_pc;
    logic              upd_taken;
    logic [c_pc_w-1:0] upd_target;
    logic              upd_is_branch;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  mis_cnt;
    logic              squashing;

    modport master (
        output stall, ex_valid, pred_taken, pred_pc, is_branch, actual_taken, br_target,
        input  flush, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_is_branch, br_cnt, mis_cnt, squashing
    );

    modport slave (
        input  stall, ex_valid, pred_taken, pred_pc, is_branch, actual_taken, br_target,
        output flush, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_is_branch, br_cnt, mis_cnt, squashing
    );

endinterface

`default_nettype wire

// File: rtl/br_resolve_sat_counter.sv
// ============================================================================
// Module   : br_resolve_sat_counter
// Brief    : WIDTH-bit incrementer that sticks at all-ones; async reset.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module br_resolve_sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/br_resolve.sv
// ============================================================================
// Module   : br_resolve
// Brief    : EX-stage branch resolution: mispredict flush/redirect, BTB update
//            packet, accuracy statistics and wrong-path shadow tracking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int SQUASH_LEN = 2,
    parameter int CNT_W      = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    br_resolve_if.slave bus
);

    localparam int SQ_W = (SQUASH_LEN < 1) ? 1 : $clog2(SQUASH_LEN + 1);

    sq_state_t         r_state;
    sq_state_t         w_state_nxt;
    logic [SQ_W-1:0]   r_sq_left;
    logic [SQ_W-1:0]   w_sq_left_nxt;
    upd_pkt_t          r_upd;

    logic              w_squashing;
    logic              w_live;
    logic              w_miss;
    logic              w_upd_fire;
    logic [c_pc_w-1:0] w_fallthru;

    assign w_squashing = (r_state == SHADOW);
    assign w_live      = bus.ex_valid & ~bus.stall & ~w_squashing;
    assign w_fallthru  = bus.pred_pc + c_instr_step;

    // Target is never compared: the BTB only caches direct targets.
    assign w_miss = w_live &
                    (( ~bus.pred_taken &  bus.is_branch & bus.actual_taken) |
                     (  bus.pred_taken & ~(bus.is_branch & bus.actual_taken)));

    // Alias hits (predicted taken on a non-branch) also produce a packet.
    assign w_upd_fire = w_live & (bus.is_branch | bus.pred_taken);

    assign bus.flush       = w_miss & ~rst;
    assign bus.redirect_pc = rst ? '0 :
                             (w_miss & ~bus.pred_taken) ? bus.br_target : w_fallthru;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sq_left <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sq_left <= w_sq_left_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sq_left_nxt = r_sq_left;
        if (!bus.stall) begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        w_state_nxt   = SHADOW;
                        w_sq_left_nxt = SQ_W'(SQUASH_LEN);
                    end
                end
                SHADOW: begin
                    // Bubbles still occupy a wrong-path slot, so count every cycle.
                    w_sq_left_nxt = r_sq_left - SQ_W'(1);
                    if (r_sq_left <= SQ_W'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_sq_left_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd <= '0;
        end else begin
            r_upd.valid <= w_upd_fire;
            if (w_upd_fire) begin
                r_upd.pc        <= bus.pred_pc;
                r_upd.taken     <= bus.actual_taken & bus.is_branch;
                r_upd.target    <= bus.br_target;
                r_upd.is_branch <= bus.is_branch;
            end
        end
    end

    assign bus.upd_valid     = r_upd.valid;
    assign bus.upd_pc        = r_upd.pc;
    assign bus.upd_taken     = r_upd.taken;
    assign bus.upd_target    = r_upd.target;
    assign bus.upd_is_branch = r_upd.is_branch;
    assign bus.squashing     = w_squashing;

    br_resolve_sat_counter #(
        .WIDTH (CNT_W)
    ) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_live & bus.is_branch),
        .count (bus.br_cnt)
    );

    br_resolve_sat_counter #(
        .WIDTH (CNT_W)
    ) u_mis_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss),
        .count (bus.mis_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_br_resolve.sv
// ============================================================================
// Module   : tb_br_resolve
// Brief    : Scoreboard bench for br_resolve, plus a 4-bit-counter twin instance.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_br_resolve;

    localparam int SQUASH_LEN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    br_resolve_if #(.CNT_W(32)) bus ();
    br_resolve_if #(.CNT_W(4))  bus_s ();

    br_resolve #(.SQUASH_LEN(SQUASH_LEN), .CNT_W(32)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    br_resolve #(.SQUASH_LEN(SQUASH_LEN), .CNT_W(4)) dut_sat (
        .clk (clk), .rst (rst), .bus (bus_s)
    );

    assign bus_s.stall        = bus.stall;
    assign bus_s.ex_valid     = bus.ex_valid;
    assign bus_s.pred_taken   = bus.pred_taken;
    assign bus_s.pred_pc      = bus.pred_pc;
    assign bus_s.is_branch    = bus.is_branch;
    assign bus_s.actual_taken = bus.actual_taken;
    assign bus_s.br_target    = bus.br_target;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } flush_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        is_branch;
    } upd_exp_t;

    flush_exp_t flush_q[$];
    upd_exp_t   upd_q[$];

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    bit          running = 1'b0;

    // Reference state: counts and how many upcoming unstalled EX slots are wrong-path.
    int unsigned m_br     = 0;
    int unsigned m_mis    = 0;
    int          m_shadow = 0;
    bit          exp_sq   = 1'b0;
    int unsigned exp_br   = 0;
    int unsigned exp_mis  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic step(input bit st, input bit ev, input bit pt, input logic [31:0] pc,
                        input bit ib, input bit at, input logic [31:0] tg);
        bit          sq;
        bit          live;
        bit          fl;
        logic [31:0] four;
        flush_exp_t  fe;
        upd_exp_t    ue;
        @(posedge clk);
        #1;
        cyc++;
        exp_sq  = (m_shadow > 0);
        exp_br  = m_br;
        exp_mis = m_mis;
        bus.stall        = st;
        bus.ex_valid     = ev;
        bus.pred_taken   = pt;
        bus.pred_pc      = pc;
        bus.is_branch    = ib;
        bus.actual_taken = at;
        bus.br_target    = tg;

        sq   = exp_sq;
        live = ev && !st && !sq;
        fl   = live && (pt != (ib && at));
        four = 32'd4;
        if (fl) begin
            fe.cyc = cyc;
            fe.pc  = pt ? (pc + four) : tg;
            flush_q.push_back(fe);
            m_mis = sat_inc(m_mis);
        end
        if (live && (ib || pt)) begin
            ue.cyc       = cyc + 1;
            ue.pc        = pc;
            ue.taken     = at && ib;
            ue.target    = tg;
            ue.is_branch = ib;
            upd_q.push_back(ue);
        end
        if (live && ib) m_br = sat_inc(m_br);
        if (!st) begin
            if (sq) m_shadow--;
            else if (fl) m_shadow = SQUASH_LEN;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (running && !rst) begin
            check("squashing", {31'd0, bus.squashing}, {31'd0, exp_sq});
            check("br_cnt", bus.br_cnt, exp_br);
            check("mis_cnt", bus.mis_cnt, exp_mis);
            check("sat_br_cnt", {28'd0, bus_s.br_cnt}, (exp_br > 15) ? 32'd15 : exp_br);

            if (bus.flush) begin
                if (flush_q.size() == 0 || flush_q[0].cyc != cyc) begin
                    check("unexpected_flush", 32'd1, 32'd0);
                end else begin
                    check("redirect_pc", bus.redirect_pc, flush_q[0].pc);
                end
                if (flush_q.size() > 0 && flush_q[0].cyc <= cyc) void'(flush_q.pop_front());
            end else if (flush_q.size() > 0 && flush_q[0].cyc <= cyc) begin
                check("missing_flush", 32'd0, 32'd1);
                void'(flush_q.pop_front());
            end

            if (bus.upd_valid) begin
                if (upd_q.size() == 0 || upd_q[0].cyc != cyc) begin
                    check("unexpected_upd", 32'd1, 32'd0);
                end else begin
                    check("upd_pc", bus.upd_pc, upd_q[0].pc);
                    check("upd_taken", {31'd0, bus.upd_taken}, {31'd0, upd_q[0].taken});
                    check("upd_target", bus.upd_target, upd_q[0].target);
                    check("upd_is_branch", {31'd0, bus.upd_is_branch}, {31'd0, upd_q[0].is_branch});
                end
                if (upd_q.size() > 0 && upd_q[0].cyc <= cyc) void'(upd_q.pop_front());
            end else if (upd_q.size() > 0 && upd_q[0].cyc <= cyc) begin
                check("missing_upd", 32'd0, 32'd1);
                void'(upd_q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_flush"}, {31'd0, bus.flush}, 32'd0);
        check({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
        check({tag, "_upd_valid"}, {31'd0, bus.upd_valid}, 32'd0);
        check({tag, "_upd_pc"}, bus.upd_pc, 32'd0);
        check({tag, "_upd_taken"}, {31'd0, bus.upd_taken}, 32'd0);
        check({tag, "_upd_target"}, bus.upd_target, 32'd0);
        check({tag, "_upd_is_branch"}, {31'd0, bus.upd_is_branch}, 32'd0);
        check({tag, "_br_cnt"}, bus.br_cnt, 32'd0);
        check({tag, "_mis_cnt"}, bus.mis_cnt, 32'd0);
        check({tag, "_squashing"}, {31'd0, bus.squashing}, 32'd0);
        check({tag, "_sat_br_cnt"}, {28'd0, bus_s.br_cnt}, 32'd0);
    endtask

    initial begin
        // A would-be mispredict on the inputs must stay invisible while in reset.
        bus.stall        = 1'b0;
        bus.ex_valid     = 1'b1;
        bus.pred_taken   = 1'b0;
        bus.pred_pc      = 32'h0000_1234;
        bus.is_branch    = 1'b1;
        bus.actual_taken = 1'b1;
        bus.br_target    = 32'h0000_0999;
        #3;
        check_all_zero("reset");
        bus.ex_valid = 1'b0;
        #9;
        rst     = 1'b0;
        running = 1'b1;

        // Correct prediction.
        step(0, 1, 1, 32'h0000_0100, 1, 1, 32'h0000_0180);
        idle();
        // Predicted not-taken, actually taken; then a mispredicting branch in the shadow.
        step(0, 1, 0, 32'h0000_0110, 1, 1, 32'h0000_0200);
        step(0, 1, 0, 32'h0000_0114, 1, 1, 32'h0000_0300);
        step(0, 1, 1, 32'h0000_0118, 1, 0, 32'h0000_0400);
        idle();
        // Predicted taken, not taken, with PC wrap.
        step(0, 1, 1, 32'hFFFF_FFFC, 1, 0, 32'h0000_0500);
        idle(); idle();
        // Alias hit on a non-branch.
        step(0, 1, 1, 32'h0000_0040, 0, 1, 32'h0000_0600);
        idle(); idle();
        // Stall during a mispredict, then a stall inside the shadow.
        step(1, 1, 0, 32'h0000_0700, 1, 1, 32'h0000_0800);
        step(0, 1, 0, 32'h0000_0700, 1, 1, 32'h0000_0800);
        step(1, 1, 0, 32'h0000_0704, 1, 1, 32'h0000_0900);
        step(1, 0, 0, 32'h0000_0708, 0, 0, 32'h0000_0000);
        step(0, 1, 0, 32'h0000_0704, 1, 1, 32'h0000_0900);
        step(0, 0, 0, 32'h0000_0708, 0, 0, 32'h0000_0000);
        step(0, 1, 1, 32'h0000_0800, 1, 1, 32'h0000_0a00);
        idle();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            logic [31:0] tg;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            tg = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                 pc, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), tg);
        end
        idle(); idle(); idle();

        // Reset in the shadow while an update packet is being presented.
        step(0, 1, 0, 32'h0000_0300, 1, 1, 32'h0000_0500);
        @(posedge clk);
        #1;
        running = 1'b0;
        check("pre_reset_squashing", {31'd0, bus.squashing}, 32'd1);
        check("pre_reset_upd_valid", {31'd0, bus.upd_valid}, 32'd1);
        bus.ex_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("midreset");
        flush_q.delete();
        upd_q.delete();
        m_br = 0; m_mis = 0; m_shadow = 0;
        exp_sq = 1'b0; exp_br = 0; exp_mis = 0;
        #1 rst = 1'b0;
        running = 1'b1;

        // Saturation of the 4-bit twin.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 32'h0000_1000 + 32'(i * 4), 1, 1, 32'h0000_2000);
        end
        idle(); idle();
        @(negedge clk);
        #1;
        check("sat_final", {28'd0, bus_s.br_cnt}, 32'h0000_000F);
        check("flush_q_empty", 32'(flush_q.size()), 32'd0);
        check("upd_q_empty", 32'(upd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
